i2c_master_tx: RTL and testbench
================================

I2C_MASTER_TX -- requirements
Module: i2c_master_tx

Interface
REQ-001 Parameter CLK_DIV, default 250, meaning clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV clk cycles; 100 kHz at 100 MHz clk); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 slave_addr  input  7  target address; captured when start is accepted.
REQ-006 tx_data  input  8  write data byte; captured when start is accepted.
REQ-007 scl  output  1  bus clock, push-pull, idle high.
REQ-008 sda  inout  1  bus data, open-drain: driven 0 or released to Z, never driven 1.
REQ-009 busy  output  1  high from start acceptance until done.
REQ-010 done  output  1  one-cycle pulse at end of every frame, including aborted ones.
REQ-011 ack_error  output  1  set when a NACK was sampled in the frame; held until next start accepted.
REQ-012 state  output  3  current FSM state encoding (see REQ-014).

Function
REQ-013 A quarter counter counts 0..CLK_DIV-1; each wrap ends one quarter. Counter is held at 0 in IDLE.
REQ-014 States, encoding: IDLE=0, START=1, ADDR=2, ADDR_ACK=3, DATA=4, DATA_ACK=5, STOP=6.
REQ-015 IDLE: scl=1, sda=Z. start=1 -> capture {slave_addr,1'b0} (R/W=0, write) and tx_data, busy=1, ack_error=0, go START next cycle.
REQ-016 START (4 quarters): Q0-Q1 scl=1 sda=Z; Q2 scl=1 sda=0 (START condition: SDA falls while SCL high); Q3 scl=0 sda=0; then ADDR.
REQ-017 Bit slot (ADDR, DATA; 4 quarters per bit, MSB first): Q0 scl=0, sda updated to bit (0 -> drive 0, 1 -> Z); Q1 scl=0; Q2-Q3 scl=1; SDA never changes while scl=1.
REQ-018 ADDR sends 8 bits (7 address + R/W=0), then ADDR_ACK; DATA sends tx_data[7:0], then DATA_ACK.
REQ-019 ACK slot (4 quarters): sda=Z all slot; scl as REQ-017; sda sampled on the last clk of Q2. 0 = ACK; 1 or Z = NACK.
REQ-020 ADDR_ACK: ACK -> DATA; NACK -> ack_error=1, skip DATA, go STOP.
REQ-021 DATA_ACK: NACK -> ack_error=1; either way go STOP.
REQ-022 STOP (4 quarters): Q0 scl=0 sda=0; Q1 scl=1 sda=0; Q2-Q3 scl=1 sda=Z (STOP condition: SDA rises while SCL high); then IDLE with done=1 for one cycle and busy=0 in that same cycle.
REQ-023 Frame length, start accepted to done: full frame 80*CLK_DIV+1 clk cycles; address NACK 44*CLK_DIV+1 clk cycles.
REQ-024 start while busy=1 is ignored; it is not queued.
REQ-025 start held high in the done cycle is ignored; start is accepted no earlier than the following cycle.
REQ-026 slave_addr and tx_data changes after acceptance do not affect the frame in flight.

Reset
REQ-027 reset=1 immediately forces: state=IDLE, scl=1, sda=Z, busy=0, done=0, ack_error=0, quarter and bit counters=0, shift register=0.
REQ-028 Reset mid-frame abandons the frame without generating STOP and without a done pulse.

Verification
REQ-029 CLK_DIV=4, addr=0x50, data=0x3C, slave ACKs both slots -> START, bits 0xA0, ACK, bits 0x3C, ACK, STOP; done at cycle 321 after acceptance; ack_error=0; i2c_slave received_data=0x3C with data_valid asserted.
REQ-030 CLK_DIV=4, addr=0x51, no device responds (sda pulled up) -> ack_error=1; no data bits on the bus; STOP follows the ADDR_ACK slot; done at cycle 177.
REQ-031 Slave ACKs address, NACKs data -> ack_error=1; full-length frame; done at cycle 321.
REQ-032 start pulsed at mid-frame with addr=0x22 -> current frame unchanged; exactly one done pulse; busy stays high with no glitch.
REQ-033 reset asserted during DATA bit 3 -> same cycle scl=1, sda=Z, state=0, busy=0; no done pulse; next start runs a clean full frame.
REQ-034 Bus checker on all tests: SDA changes while SCL=1 only at START/STOP points; sda is never driven 1.

Source files
------------

// File: rtl/i2c_master_tx.sv
// i2c_master_tx: single-byte I2C write master.
// Each frame is START, 7-bit address with R/W=0, address ACK, one data byte,
// data ACK, then STOP. An address NACK skips the data byte.
// SCL is push-pull. SDA is open-drain: the module only drives it low or releases it.
module i2c_master_tx #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] slave_addr,
  input  logic [7:0] tx_data,
  output logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    DATA     = 3'd4,
    DATA_ACK = 3'd5,
    STOP     = 3'd6
  } state_t;

  state_t      st, nxt_st;
  logic [15:0] qcnt, nxt_qcnt;
  logic [1:0]  quarter, nxt_q;
  logic [2:0]  bit_cnt, nxt_bit;
  logic [7:0]  shift, nxt_shift;
  logic [7:0]  data_r, nxt_data;
  logic        nxt_busy, nxt_done, nxt_ack_err;
  logic        nxt_scl, nxt_low;
  logic        sda_low;
  logic        tick;

  assign state = st;
  assign sda   = sda_low ? 1'b0 : 1'bz;
  assign tick  = (qcnt == 16'(CLK_DIV - 1));

  // Next-state logic. Bus levels are decoded from the next state so that
  // scl/sda are registered and change on the same edge as the state.
  always_comb begin
    nxt_st      = st;
    nxt_qcnt    = qcnt;
    nxt_q       = quarter;
    nxt_bit     = bit_cnt;
    nxt_shift   = shift;
    nxt_data    = data_r;
    nxt_busy    = busy;
    nxt_done    = 1'b0;
    nxt_ack_err = ack_error;
    if (st == IDLE) begin
      nxt_qcnt = '0;
      // Ignore start while done is high, so a start held across the end of a frame waits one cycle.
      if (start && !done) begin
        nxt_st      = START;
        nxt_shift   = {slave_addr, 1'b0};
        nxt_data    = tx_data;
        nxt_busy    = 1'b1;
        nxt_ack_err = 1'b0;
        nxt_q       = '0;
        nxt_bit     = '0;
      end
    end else begin
      nxt_qcnt = tick ? '0 : qcnt + 16'd1;
      if (tick) begin
        nxt_q = quarter + 2'd1;
        // Sample the ACK bit on the last clk of Q2, while SCL is high.
        if (quarter == 2'd2 && (st == ADDR_ACK || st == DATA_ACK) && sda != 1'b0)
          nxt_ack_err = 1'b1;
        if (quarter == 2'd3) begin
          case (st)
            START: begin
              nxt_st  = ADDR;
              nxt_bit = 3'd7;
            end
            ADDR, DATA: begin
              if (bit_cnt == 3'd0) begin
                nxt_st = (st == ADDR) ? ADDR_ACK : DATA_ACK;
              end else begin
                nxt_bit   = bit_cnt - 3'd1;
                nxt_shift = {shift[6:0], 1'b0};
              end
            end
            ADDR_ACK: begin
              if (ack_error) begin
                nxt_st = STOP;
              end else begin
                nxt_st    = DATA;
                nxt_shift = data_r;
                nxt_bit   = 3'd7;
              end
            end
            DATA_ACK: nxt_st = STOP;
            STOP: begin
              nxt_st   = IDLE;
              nxt_done = 1'b1;
              nxt_busy = 1'b0;
              nxt_bit  = '0;
            end
            default: nxt_st = IDLE;
          endcase
        end
      end
    end

    nxt_scl = 1'b1;
    nxt_low = 1'b0;
    case (nxt_st)
      START: begin
        nxt_scl = (nxt_q != 2'd3);
        nxt_low = nxt_q[1];
      end
      ADDR, DATA: begin
        nxt_scl = nxt_q[1];
        nxt_low = ~nxt_shift[7];
      end
      ADDR_ACK, DATA_ACK: begin
        nxt_scl = nxt_q[1];
        nxt_low = 1'b0;
      end
      STOP: begin
        nxt_scl = (nxt_q != 2'd0);
        nxt_low = ~nxt_q[1];
      end
      default: begin
        nxt_scl = 1'b1;
        nxt_low = 1'b0;
      end
    endcase
  end

  // State and registered bus outputs. Reset releases the bus at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      qcnt      <= '0;
      quarter   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data_r    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
      scl       <= 1'b1;
      sda_low   <= 1'b0;
    end else begin
      st        <= nxt_st;
      qcnt      <= nxt_qcnt;
      quarter   <= nxt_q;
      bit_cnt   <= nxt_bit;
      shift     <= nxt_shift;
      data_r    <= nxt_data;
      busy      <= nxt_busy;
      done      <= nxt_done;
      ack_error <= nxt_ack_err;
      scl       <= nxt_scl;
      sda_low   <= nxt_low;
    end
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Directed bench for i2c_master_tx with CLK_DIV=4 and a behavioural slave on the bus.
module tb_i2c_master_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] slave_addr;
  logic [7:0] tx_data;
  logic       scl;
  wire        sda;
  logic       busy, done, ack_error;
  logic [2:0] state;

  logic slv_low = 1'b0;
  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_master_tx #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .slave_addr(slave_addr),
    .tx_data(tx_data), .scl(scl), .sda(sda), .busy(busy), .done(done),
    .ack_error(ack_error), .state(state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int ncyc = 0;
  int busy_glitch = 0;
  logic in_frame = 1'b0;

  // Slave and bus monitor. Samples on the falling clk edge.
  logic       pscl = 1'b1, psda = 1'b1;
  int         bitn = 0, nbytes = 0, starts = 0, stops = 0, done_cnt = 0;
  logic [7:0] sh = '0;
  logic [7:0] bytes_seen [0:3];
  logic [7:0] received_data = '0;
  logic       data_valid = 1'b0;
  logic       data_ack_en = 1'b1;

  always @(negedge clk) begin
    if (reset) begin
      slv_low = 1'b0;
      bitn = 0;
      pscl = 1'b1;
      psda = 1'b1;
    end else begin
      if (pscl && scl && psda && !sda) begin
        starts++;
        bitn = 0;
        nbytes = 0;
        data_valid = 1'b0;
      end else if (pscl && scl && !psda && sda) begin
        stops++;
      end else if (!pscl && scl) begin
        if (bitn < 8) begin
          sh = {sh[6:0], sda};
          bitn++;
        end else begin
          bitn = 9;
        end
      end else if (pscl && !scl) begin
        if (bitn == 8) begin
          if (nbytes < 4) bytes_seen[nbytes] = sh;
          if (nbytes == 1) begin
            received_data = sh;
            data_valid = 1'b1;
          end
          slv_low = (nbytes == 0) ? (sh == 8'hA0) : data_ack_en;
        end else if (bitn == 9) begin
          slv_low = 1'b0;
          bitn = 0;
          nbytes++;
        end
      end
      if (done) done_cnt++;
      pscl = scl;
      psda = sda;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
    ncyc++;
    if (in_frame && !done && busy !== 1'b1) busy_glitch++;
  endtask

  task automatic step_to(input int target);
    while (ncyc < target) tick1();
  endtask

  task automatic launch(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    slave_addr = a;
    tx_data = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ncyc = 1;
    in_frame = 1'b1;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_state", 32'(state), 32'd1);
    chk("accept_ack_err_clr", 32'(ack_error), 32'd0);
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && ncyc < 2000) tick1();
    in_frame = 1'b0;
  endtask

  int s0, p0, d0;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    slave_addr = '0;
    tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack_err", 32'(ack_error), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full frame, both slots ACKed.
    s0 = starts; p0 = stops; d0 = done_cnt;
    launch(7'h50, 8'h3C);
    step_to(10);
    chk("start_q2_scl", 32'(scl), 32'd1);
    chk("start_q2_sda", 32'(sda), 32'd0);
    step_to(14);
    chk("start_q3_scl", 32'(scl), 32'd0);
    chk("start_q3_sda", 32'(sda), 32'd0);
    step_to(18);
    chk("addr_b7_q0_scl", 32'(scl), 32'd0);
    chk("addr_b7_q0_sda", 32'(sda), 32'd1);
    step_to(42);
    chk("addr_b6_q2_scl", 32'(scl), 32'd1);
    chk("addr_b6_q2_sda", 32'(sda), 32'd0);
    wait_done();
    chk("t1_len", 32'(ncyc), 32'd321);
    chk("t1_busy_in_done", 32'(busy), 32'd0);
    chk("t1_ack_err", 32'(ack_error), 32'd0);
    tick1();
    chk("t1_done_one_cycle", 32'(done), 32'd0);
    chk("t1_addr_byte", 32'(bytes_seen[0]), 32'h A0);
    chk("t1_data_byte", 32'(bytes_seen[1]), 32'h3C);
    chk("t1_nbytes", 32'(nbytes), 32'd2);
    chk("t1_received", 32'(received_data), 32'h3C);
    chk("t1_data_valid", 32'(data_valid), 32'd1);
    chk("t1_starts", 32'(starts - s0), 32'd1);
    chk("t1_stops", 32'(stops - p0), 32'd1);
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Address NACK: nobody answers 0x51.
    s0 = starts; p0 = stops;
    launch(7'h51, 8'hFF);
    wait_done();
    chk("t2_len", 32'(ncyc), 32'd177);
    chk("t2_ack_err", 32'(ack_error), 32'd1);
    chk("t2_addr_byte", 32'(bytes_seen[0]), 32'h A2);
    chk("t2_nbytes", 32'(nbytes), 32'd1);
    chk("t2_starts", 32'(starts - s0), 32'd1);
    chk("t2_stops", 32'(stops - p0), 32'd1);
    repeat (3) tick1();
    chk("t2_ack_err_held", 32'(ack_error), 32'd1);

    // Address ACKed, data NACKed.
    data_ack_en = 1'b0;
    launch(7'h50, 8'h5A);
    wait_done();
    chk("t3_len", 32'(ncyc), 32'd321);
    chk("t3_ack_err", 32'(ack_error), 32'd1);
    chk("t3_received", 32'(received_data), 32'h5A);
    data_ack_en = 1'b1;

    // Start held from the done cycle is taken one cycle later.
    slave_addr = 7'h50;
    tx_data = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_done_state", 32'(state), 32'd0);
    chk("hold_done_busy", 32'(busy), 32'd0);
    chk("hold_done_pulse", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    ncyc = 1;
    chk("hold_accept_state", 32'(state), 32'd1);
    chk("hold_accept_ack_clr", 32'(ack_error), 32'd0);

    // Reset during DATA bit 3 (Q2, SCL high).
    d0 = done_cnt;
    step_to(234);
    chk("t4_pre_state", 32'(state), 32'd4);
    reset = 1'b1;
    #1;
    chk("t4_scl", 32'(scl), 32'd1);
    chk("t4_sda", 32'(sda), 32'd1);
    chk("t4_state", 32'(state), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) tick1();
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);

    // Clean frame after reset, with a start pulse and input changes mid-frame.
    s0 = starts; p0 = stops; d0 = done_cnt; busy_glitch = 0;
    launch(7'h50, 8'h3C);
    step_to(150);
    start = 1'b1;
    slave_addr = 7'h22;
    tx_data = 8'h00;
    tick1();
    start = 1'b0;
    wait_done();
    chk("t5_len", 32'(ncyc), 32'd321);
    chk("t5_addr_byte", 32'(bytes_seen[0]), 32'h A0);
    chk("t5_data_byte", 32'(bytes_seen[1]), 32'h3C);
    chk("t5_ack_err", 32'(ack_error), 32'd0);
    repeat (6) tick1();
    chk("t5_not_queued", 32'(state), 32'd0);
    chk("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t5_starts", 32'(starts - s0), 32'd1);
    chk("t5_stops", 32'(stops - p0), 32'd1);
    chk("busy_glitch", 32'(busy_glitch), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
